// File: rtl/jtopl_dac_ser_pkg.sv
// Shared constants and helpers for the jtopl DAC serialiser: frame length, word
// and DC-state widths, and the DC-state saturation helper.
package jtopl_dac_ser_pkg;

  localparam int FRAME_BITS = 32;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int WORD_W     = 16;
  localparam int DC_W       = 20;
  localparam int ACC_W      = DC_W + 2;

  localparam logic signed [ACC_W-1:0] DC_MAX = 22'sd524287;
  localparam logic signed [ACC_W-1:0] DC_MIN = -22'sd524288;

  typedef logic signed [WORD_W-1:0] sample_t;

  // Clamping y to the 20-bit state range makes y[19:4] equal to sat16(y >>> 4).
  function automatic logic signed [DC_W-1:0] sat_dc(input logic signed [ACC_W-1:0] v);
    logic signed [DC_W-1:0] r;
    if (v > DC_MAX) begin
      r = DC_MAX[DC_W-1:0];
    end else if (v < DC_MIN) begin
      r = DC_MIN[DC_W-1:0];
    end else begin
      r = v[DC_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/jtopl_dcblk.sv
// First-order DC blocker with 16-bit saturated output; state advances only on en.
// Compiled only when JTOPL_DCBLK_EN is defined.
`ifdef JTOPL_DCBLK_EN
module jtopl_dcblk
  import jtopl_dac_ser_pkg::*;
#(
  parameter int DCK = 9
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  sample_t x,
  output sample_t y
);

  sample_t                  x1_r;
  logic signed [DC_W-1:0]   y1_r;
  logic signed [ACC_W-1:0]  acc_s;
  logic signed [DC_W-1:0]   y_sat_s;

  // Filter difference equation evaluated on the incoming sample.
  always_comb begin
    acc_s = ($signed({{(ACC_W-WORD_W){x[WORD_W-1]}}, x}) <<< 4)
          - ($signed({{(ACC_W-WORD_W){x1_r[WORD_W-1]}}, x1_r}) <<< 4)
          + $signed({{(ACC_W-DC_W){y1_r[DC_W-1]}}, y1_r})
          - $signed({{(ACC_W-DC_W){y1_r[DC_W-1]}}, (y1_r >>> DCK)});
    y_sat_s = sat_dc(acc_s);
    y       = y_sat_s[DC_W-1:DC_W-WORD_W];
  end

  // Filter state, updated once per captured sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1_r <= '0;
      y1_r <= '0;
    end else if (en) begin
      x1_r <= x;
      y1_r <= y_sat_s;
    end else begin
      x1_r <= x1_r;
      y1_r <= y1_r;
    end
  end

endmodule
`endif

// File: rtl/jtopl_dac_ser.sv
// Captures the mixed sample once per frame and streams it as mono left-justified
// serial audio. Define JTOPL_DCBLK_EN to insert the DC blocker ahead of the hold register.
module jtopl_dac_ser
  import jtopl_dac_ser_pkg::*;
#(
  parameter int DIV = 4,
  parameter int DCK = 9
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    cenop,
  input  logic    sample,
  input  sample_t snd,
  output logic    dac_bck,
  output logic    dac_lrck,
  output logic    dac_data,
  output sample_t sample_out,
  output logic    sample_vld,
  output logic    ovr,
  output logic    udr
);

  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  if (DIV < 2 || DCK < 0) begin : g_bad_cfg
  end

  logic [DW-1:0]     div_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [BIT_W-1:0]  bit_nxt_s;
  logic [WORD_W-1:0] word_r;
  logic              pend_r;
  logic              cap_s;
  logic              div_wrap_s;
  logic              fall_s;
  logic              load_s;
  logic              data_nxt_s;
  sample_t           filt_s;

`ifdef JTOPL_DCBLK_EN
  jtopl_dcblk #(.DCK(DCK)) u_dcblk (
    .clk (clk),
    .rst (rst),
    .en  (cap_s),
    .x   (snd),
    .y   (filt_s)
  );
`else
  assign filt_s = snd;
`endif

  // Edge/strobe decode; the first bit of a freshly loaded frame comes from the hold register.
  always_comb begin
    cap_s      = sample & cenop;
    div_wrap_s = (div_cnt_r == DIV_LAST);
    fall_s     = div_wrap_s & dac_bck;
    bit_nxt_s  = bit_cnt_r + 5'd1;
    load_s     = fall_s & (bit_nxt_s == 5'd0);
    if (load_s) begin
      data_nxt_s = sample_out[WORD_W-1];
    end else begin
      data_nxt_s = word_r[4'd15 - bit_nxt_s[3:0]];
    end
  end

  // Bit-clock divider and serial shift-out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r <= '0;
      bit_cnt_r <= '0;
      dac_bck   <= 1'b0;
      dac_lrck  <= 1'b0;
      dac_data  <= 1'b0;
    end else begin
      div_cnt_r <= div_wrap_s ? '0 : div_cnt_r + 1'b1;
      if (div_wrap_s) begin
        dac_bck <= ~dac_bck;
      end
      if (fall_s) begin
        bit_cnt_r <= bit_nxt_s;
        dac_lrck  <= bit_nxt_s[BIT_W-1];
        dac_data  <= data_nxt_s;
      end
    end
  end

  // Sample capture, frame load and the pend/ovr/udr bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_out <= '0;
      sample_vld <= 1'b0;
      word_r     <= '0;
      pend_r     <= 1'b0;
      ovr        <= 1'b0;
      udr        <= 1'b0;
    end else begin
      sample_vld <= cap_s;
      if (cap_s) begin
        sample_out <= filt_s;
      end
      if (load_s) begin
        word_r <= sample_out;
        pend_r <= cap_s;
        if (!pend_r) begin
          udr <= 1'b1;
        end
      end else if (cap_s) begin
        pend_r <= 1'b1;
        if (pend_r) begin
          ovr <= 1'b1;
        end
      end
    end
  end

endmodule
